// File: rtl/tlight_pkg.sv
// Shared lamp encodings, fault codes and lamp-sequence helpers for the traffic-light monitor.
package tlight_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [2:0] {
        NONE        = 3'd0,
        ENCODING    = 3'd1,
        CONFLICT    = 3'd2,
        SEQUENCE    = 3'd3,
        DWELL_SHORT = 3'd4,
        DWELL_LONG  = 3'd5,
        STALL       = 3'd6
    } fault_code_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == RED) || (v == YELLOW) || (v == GREEN);
    endfunction

    // Legal colour change only; callers decide whether a change happened at all.
    function automatic logic legal_step(input logic [2:0] from_c, input logic [2:0] to_c);
        logic ok;
        case (from_c)
            RED:     ok = (to_c == YELLOW);
            YELLOW:  ok = (to_c == RED) || (to_c == GREEN);
            GREEN:   ok = (to_c == YELLOW);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tlight_monitor_dwell.sv
// light_dwell_tracker: per-direction previous colour and dwell counter with sequence/dwell checks.
module light_dwell_tracker
    import tlight_pkg::*;
#(
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 4,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] lamp,
    input  logic       reload,
    output logic       seq_err,
    output logic       short_err,
    output logic       long_err,
    output logic       is_red
);

    localparam int DW = $clog2(GREEN_MAX + 2);
    localparam logic [DW-1:0] DWELL_SAT = DW'(GREEN_MAX + 1);
    localparam logic [DW-1:0] Y_MIN_C   = DW'(YELLOW_MIN);
    localparam logic [DW-1:0] Y_MAX_C   = DW'(YELLOW_MAX);
    localparam logic [DW-1:0] G_MIN_C   = DW'(GREEN_MIN);
    localparam logic [DW-1:0] G_MAX_C   = DW'(GREEN_MAX);
    localparam logic [DW-1:0] ONE_C     = DW'(1);

    logic [2:0]    prev_q, prev_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          changed;

    // Next-state and violation flags from the current sample against the held colour.
    always_comb begin
        changed   = (lamp != prev_q);
        seq_err   = 1'b0;
        short_err = 1'b0;
        long_err  = 1'b0;
        is_red    = (lamp == RED);
        prev_d    = lamp;
        dwell_d   = dwell_q;

        if (reload || changed) begin
            dwell_d = ONE_C;
        end else if (dwell_q != DWELL_SAT) begin
            dwell_d = dwell_q + ONE_C;
        end else begin
            dwell_d = dwell_q;
        end

        if (changed && !reload) begin
            seq_err   = !legal_step(prev_q, lamp);
            short_err = ((prev_q == YELLOW) && (dwell_q < Y_MIN_C)) ||
                        ((prev_q == GREEN)  && (dwell_q < G_MIN_C));
        end else begin
            seq_err   = 1'b0;
            short_err = 1'b0;
        end

        // Fires only on the sample that first exceeds the maximum.
        if (!changed) begin
            long_err = ((lamp == YELLOW) && (dwell_q == Y_MAX_C)) ||
                       ((lamp == GREEN)  && (dwell_q == G_MAX_C));
        end else begin
            long_err = 1'b0;
        end
    end

    // Colour/dwell state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q  <= RED;
            dwell_q <= '0;
        end else begin
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/tlight_monitor.sv
// Conflict monitor and fail-safe gate on the ns/we lamp bus; forces flashing yellow on a fault.
// Optional macro TLMON_VIOL_CNT_EN adds the saturating viol_cnt output.
module tlight_monitor
    import tlight_pkg::*;
#(
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 4,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 20,
    parameter int ALLRED_MAX = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] ns,
    input  logic [2:0] we,
    input  logic       clear,
    output logic [2:0] ns_safe,
    output logic [2:0] we_safe,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef TLMON_VIOL_CNT_EN
    ,
    output logic [7:0] viol_cnt
`endif
);

    localparam int AW = $clog2(ALLRED_MAX + 2);
    localparam logic [AW-1:0] ALLRED_LIM = AW'(ALLRED_MAX);
    localparam logic [AW-1:0] ALLRED_SAT = AW'(ALLRED_MAX + 1);
    localparam logic [AW-1:0] A_ONE      = AW'(1);

    logic ns_seq, ns_short, ns_long, ns_red;
    logic we_seq, we_short, we_long, we_red;

    logic        enc_err, conflict_err, seq_err, short_err, long_err, stall_err;
    logic        both_red, viol;
    fault_code_e viol_code;

    logic [AW-1:0] allred_q, allred_d;
    logic [2:0]    ns_safe_q, ns_safe_d, we_safe_q, we_safe_d;
    logic          fault_q, fault_d, blink_q, blink_d;
    logic [2:0]    fault_code_q, fault_code_d;

    light_dwell_tracker #(
        .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX),
        .GREEN_MIN(GREEN_MIN),   .GREEN_MAX(GREEN_MAX)
    ) u_ns_trk (
        .clock(clock), .reset(reset), .lamp(ns), .reload(clear),
        .seq_err(ns_seq), .short_err(ns_short), .long_err(ns_long), .is_red(ns_red)
    );

    light_dwell_tracker #(
        .YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX),
        .GREEN_MIN(GREEN_MIN),   .GREEN_MAX(GREEN_MAX)
    ) u_we_trk (
        .clock(clock), .reset(reset), .lamp(we), .reload(clear),
        .seq_err(we_seq), .short_err(we_short), .long_err(we_long), .is_red(we_red)
    );

    // Per-sample violation flags and lowest-code-wins priority.
    always_comb begin
        enc_err      = !is_onehot3(ns) || !is_onehot3(we);
        conflict_err = (ns != RED) && (we != RED);
        seq_err      = ns_seq || we_seq;
        short_err    = ns_short || we_short;
        long_err     = ns_long || we_long;
        both_red     = ns_red && we_red;
        stall_err    = both_red && (allred_q == ALLRED_LIM);
        viol         = enc_err || conflict_err || seq_err || short_err || long_err || stall_err;

        if (enc_err) begin
            viol_code = ENCODING;
        end else if (conflict_err) begin
            viol_code = CONFLICT;
        end else if (seq_err) begin
            viol_code = SEQUENCE;
        end else if (short_err) begin
            viol_code = DWELL_SHORT;
        end else if (long_err) begin
            viol_code = DWELL_LONG;
        end else if (stall_err) begin
            viol_code = STALL;
        end else begin
            viol_code = NONE;
        end
    end

    // All-red run counter, fault latch and output gate.
    always_comb begin
        allred_d     = allred_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        blink_d      = blink_q;
        ns_safe_d    = ns;
        we_safe_d    = we;

        if (!both_red) begin
            allred_d = '0;
        end else if (clear) begin
            allred_d = A_ONE;
        end else if (allred_q != ALLRED_SAT) begin
            allred_d = allred_q + A_ONE;
        end else begin
            allred_d = allred_q;
        end

        if (viol || fault_q) begin
            ns_safe_d = blink_q ? DARK : YELLOW;
            we_safe_d = blink_q ? DARK : YELLOW;
            blink_d   = ~blink_q;
        end else begin
            ns_safe_d = ns;
            we_safe_d = we;
        end

        // A clear that coincides with a violation re-arms the code with the new one.
        if (viol) begin
            fault_d = 1'b1;
            if (!fault_q || clear) begin
                fault_code_d = viol_code;
            end else begin
                fault_code_d = fault_code_q;
            end
        end else if (clear) begin
            fault_d      = 1'b0;
            fault_code_d = NONE;
            blink_d      = 1'b0;
        end else begin
            fault_d      = fault_q;
            fault_code_d = fault_code_q;
        end
    end

    // Monitor state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            allred_q     <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= NONE;
            blink_q      <= 1'b0;
            ns_safe_q    <= RED;
            we_safe_q    <= RED;
        end else begin
            allred_q     <= allred_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            blink_q      <= blink_d;
            ns_safe_q    <= ns_safe_d;
            we_safe_q    <= we_safe_d;
        end
    end

    assign ns_safe    = ns_safe_q;
    assign we_safe    = we_safe_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

`ifdef TLMON_VIOL_CNT_EN
    logic [7:0] viol_cnt_q, viol_cnt_d;

    // Saturating violation-cycle count; only reset clears it.
    always_comb begin
        if (viol && (viol_cnt_q != 8'd255)) begin
            viol_cnt_d = viol_cnt_q + 8'd1;
        end else begin
            viol_cnt_d = viol_cnt_q;
        end
    end

    // Violation counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            viol_cnt_q <= 8'd0;
        end else begin
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign viol_cnt = viol_cnt_q;
`endif

endmodule
